// File: rtl/mod2011_pkg.sv
// Shared constants and types for the mod-2011 residue accumulator.
// Residues are RW bits wide and always reduced below MOD.
package mod2011_pkg;

  localparam int RW        = 11;
  localparam int MOD       = 2011;
  localparam int NUM_TERMS = 50;

  typedef logic [RW-1:0] residue_t;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_t;

  localparam residue_t MOD_R = residue_t'(MOD);

  // Single compare-subtract; valid whenever x < 2*MOD.
  function automatic residue_t cond_sub(input logic [RW:0] x);
    logic [RW:0] m;
    m = {1'b0, MOD_R};
    return (x >= m) ? residue_t'(x - m) : residue_t'(x);
  endfunction

endpackage

// File: rtl/mod2011_add.sv
// Combinational modular adder: y = (a + b) mod MOD, with a, b < MOD.
// The sum is formed one bit wider so the carry is never lost.
module mod2011_add
  import mod2011_pkg::*;
(
  input  logic [RW-1:0] a,
  input  logic [RW-1:0] b,
  output logic [RW-1:0] y
);

  logic [RW:0] s;

  assign s = {1'b0, a} + {1'b0, b};
  assign y = cond_sub(s);

endmodule

// File: rtl/mod2011_residue_acc.sv
// Streaming accumulator summing NUM_TERMS LUT residues modulo 2011.
// Optional sticky range_err port under MOD2011_RANGE_CHECK_EN.
module mod2011_residue_acc
  import mod2011_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_residue,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_residue,
  output logic [5:0]    term_cnt
`ifdef MOD2011_RANGE_CHECK_EN
  ,
  output logic          range_err
`endif
);

  acc_state_t state;
  acc_state_t nstate;

  residue_t acc;
  residue_t r;
  residue_t s;

  logic in_xfer;
  logic out_xfer;
  logic last;

  // Out-of-range LUT outputs are < 2*MOD, so one subtract reduces them.
  assign r = cond_sub({1'b0, in_residue});

  mod2011_add u_add (
    .a (acc),
    .b (r),
    .y (s)
  );

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign last     = (term_cnt == 6'(NUM_TERMS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ACCUM: if (in_xfer && last) nstate = DONE;
      DONE:  if (out_xfer)        nstate = ACCUM;
      default: nstate = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACCUM:   in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc         <= '0;
      term_cnt    <= '0;
      out_residue <= '0;
    end else if (in_xfer) begin
      if (last) begin
        out_residue <= s;
        acc         <= '0;
        term_cnt    <= '0;
      end else begin
        acc      <= s;
        term_cnt <= term_cnt + 6'd1;
      end
    end
  end

`ifdef MOD2011_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n || out_xfer) begin
      range_err <= 1'b0;
    end else if (in_xfer && (in_residue >= MOD_R)) begin
      range_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mod2011_residue_acc.sv
// Randomized and directed checks of mod2011_residue_acc against
// an arithmetic frame-sum model.
module tb_mod2011_residue_acc;
  import mod2011_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_residue;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_residue;
  logic [5:0]    term_cnt;
`ifdef MOD2011_RANGE_CHECK_EN
  logic          range_err;
`endif

  always #5 clk = ~clk;

  mod2011_residue_acc dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_residue  (in_residue),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_residue (out_residue),
    .term_cnt    (term_cnt)
`ifdef MOD2011_RANGE_CHECK_EN
    ,
    .range_err   (range_err)
`endif
  );

  int nvec = 0;
  int nerr = 0;
  bit err_exp;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_err(input string tag);
`ifdef MOD2011_RANGE_CHECK_EN
    chk(tag, 32'(range_err), 32'(err_exp));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_accum(input int cnt);
    chk("acc_in_ready", 32'(in_ready), 1);
    chk("acc_out_valid", 32'(out_valid), 0);
    chk("acc_term_cnt", 32'(term_cnt), 32'(cnt));
    chk_err("acc_range_err");
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_residue = '0;
    tick();
    rst_n = 1'b1;
    err_exp = 1'b0;
    check_accum(0);
    chk("rst_out_residue", 32'(out_residue), 0);
  endtask

  // Present vals[0..cnt-1]; idle_pct gives random bubbles.
  task automatic feed(input int vals[$], input int cnt,
                      input int idle_pct, input int hold,
                      output int sum);
    sum = 0;
    for (int i = 0; i < cnt; i++) begin
      while (int'($urandom_range(99)) < idle_pct) begin
        in_valid   = 1'b0;
        in_residue = RW'($urandom);
        out_ready  = 1'($urandom_range(1));
        check_accum(i);
        tick();
      end
      check_accum(i);
      in_valid   = 1'b1;
      in_residue = RW'(vals[i]);
      out_ready  = (i == NUM_TERMS - 1) ? (hold == 0)
                                        : 1'($urandom_range(1));
      sum = (sum + vals[i] % MOD) % MOD;
      if (vals[i] >= MOD) err_exp = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int vals[$], input int hold,
                           input int idle_pct);
    int sum;
    feed(vals, NUM_TERMS, idle_pct, hold, sum);
    for (int h = 0; h <= hold; h++) begin
      chk("done_out_valid", 32'(out_valid), 1);
      chk("done_in_ready", 32'(in_ready), 0);
      chk("done_out_residue", 32'(out_residue), 32'(sum));
      chk("done_term_cnt", 32'(term_cnt), 0);
      chk_err("done_range_err");
      out_ready  = (h == hold);
      in_valid   = 1'($urandom_range(1));
      in_residue = RW'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_exp   = 1'b0;
    check_accum(0);
  endtask

  initial begin
    int q[$];
    int sum;
    do_reset();

    q = {};
    for (int i = 0; i < NUM_TERMS; i++) q.push_back(1);
    run_frame(q, 0, 0);

    q = {};
    for (int i = 0; i < NUM_TERMS; i++) q.push_back(2010);
    run_frame(q, 2, 0);

    q = {};
    for (int i = 0; i < NUM_TERMS; i++) q.push_back(i % 2 ? 1011 : 1000);
    run_frame(q, 0, 0);

    q = {};
    for (int i = 0; i < NUM_TERMS; i++) q.push_back(2047);
    run_frame(q, 1, 0);

    q = {};
    for (int i = 0; i < NUM_TERMS; i++) q.push_back(1);
    run_frame(q, 5, 0);

    q = {};
    for (int i = 0; i < NUM_TERMS; i++) q.push_back(100);
    feed(q, 20, 0, 1, sum);
    do_reset();
    q = {};
    for (int i = 0; i < NUM_TERMS; i++) q.push_back(1);
    run_frame(q, 0, 0);

    for (int f = 0; f < 20; f++) begin
      q = {};
      for (int i = 0; i < NUM_TERMS; i++) begin
        if ($urandom_range(3) == 0)
          q.push_back(int'($urandom_range(2047, 1900)));
        else
          q.push_back(int'($urandom_range(2010)));
      end
      run_frame(q, int'($urandom_range(3)), 30);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
